// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
//   First-word-fall-through instruction queue between the fetch unit and
//   decode. Fetch pushes {pc, instruction} pairs; decode pops the head while
//   i_busy is low. i_flush empties the queue on a redirect and drops any
//   push made in the same cycle.
//
// Ports
//   i_clock       clock, rising edge
//   i_reset       asynchronous reset, active low
//   i_flush       discard all entries and any same-cycle push
//   i_push_valid  fetch presents an entry
//   i_push_pc     PC of the pushed instruction
//   i_push_data   pushed instruction word
//   o_push_ready  queue accepts a push this cycle (not full)
//   o_valid       head entry valid
//   o_pc          PC of head entry
//   o_data        instruction word of head entry
//   i_busy        decode stalled; head is held
//   o_count       current occupancy
//   o_empty       occupancy == 0
//   o_full        occupancy == DEPTH
module cpu_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_push_valid,
  input  logic [AW-1:0]              i_push_pc,
  input  logic [DW-1:0]              i_push_data,
  output logic                       o_push_ready,
  output logic                       o_valid,
  output logic [AW-1:0]              o_pc,
  output logic [DW-1:0]              o_data,
  input  logic                       i_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned EW    = AW + DW;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_fire;
  logic             pop_fire;
  logic [EW-1:0]    head;

  // Status flags come only from the registered count, so o_push_ready has no
  // combinational path from i_busy and a full queue refuses a push even when
  // a pop fires in the same cycle.
  assign o_empty      = (count_q == '0);
  assign o_full       = (count_q == CNT_W'(DEPTH));
  assign o_push_ready = ~o_full;
  assign o_count      = count_q;

  // Flush masks the head immediately so decode never consumes a stale entry.
  assign o_valid = ~o_empty & ~i_flush;

  assign head   = mem_q[rd_ptr_q];
  assign o_pc   = head[EW-1:DW];
  assign o_data = head[DW-1:0];

  assign push_fire = i_push_valid & o_push_ready & ~i_flush;
  assign pop_fire  = o_valid & ~i_busy;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed while o_valid=1.
  always_ff @(posedge i_clock) begin
    if (push_fire) mem_q[wr_ptr_q] <= {i_push_pc, i_push_data};
  end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
module tb_cpu_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_push_valid = 1'b0;
  logic [AW-1:0] i_push_pc = '0;
  logic [DW-1:0] i_push_data = '0;
  logic          o_push_ready;
  logic          o_valid;
  logic [AW-1:0] o_pc;
  logic [DW-1:0] o_data;
  logic          i_busy = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference contents, oldest entry first.
  logic [AW+DW-1:0] model_q[$];

  cpu_fetch_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_push_valid (i_push_valid),
    .i_push_pc    (i_push_pc),
    .i_push_data  (i_push_data),
    .o_push_ready (o_push_ready),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_data       (o_data),
    .i_busy       (i_busy),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_full       (o_full)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue semantics: a push lands if there was room before the edge,
  // a pop removes the oldest entry, flush or reset empties everything.
  always @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      model_q.delete();
    end else if (i_flush) begin
      model_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = i_push_valid && (model_q.size() < DEPTH);
      do_pop  = (model_q.size() > 0) && !i_busy;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({i_push_pc, i_push_data});
    end
  end

  always @(negedge i_clock) begin
    if (chk_en && i_reset) begin
      bit exp_valid;
      exp_valid = (model_q.size() > 0) && !i_flush;
      chk("m_valid", 64'(o_valid), 64'(exp_valid));
      chk("m_count", 64'(o_count), 64'(model_q.size()));
      chk("m_empty", 64'(o_empty), 64'(model_q.size() == 0));
      chk("m_full",  64'(o_full),  64'(model_q.size() == DEPTH));
      chk("m_ready", 64'(o_push_ready), 64'(model_q.size() != DEPTH));
      if (exp_valid) begin
        chk("m_pc",   64'(o_pc),   64'(model_q[0][AW+DW-1:DW]));
        chk("m_data", 64'(o_data), 64'(model_q[0][DW-1:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_push(input bit v, input logic [AW-1:0] pc, input logic [DW-1:0] d);
    i_push_valid = v;
    i_push_pc    = pc;
    i_push_data  = d;
  endtask

  initial begin
    #2 i_reset = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_full",  64'(o_full),  64'd0);
    chk("rst_ready", 64'(o_push_ready), 64'd1);
    cyc();
    cyc();
    i_reset = 1'b1;
    chk_en  = 1'b1;

    // single entry, one-cycle latency
    set_push(1, 32'h100, 32'h00000013);
    #1 chk("no_bypass", 64'(o_valid), 64'd0);
    cyc();
    set_push(0, '0, '0);
    #1;
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_pc",    64'(o_pc),    64'h100);
    chk("t1_data",  64'(o_data),  64'h13);
    cyc();
    chk("t1_valid2", 64'(o_valid), 64'd0);
    chk("t1_count2", 64'(o_count), 64'd0);

    // fill under stall, refuse fifth push, drain in order
    i_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_push(1, AW'(4*i), DW'(32'hA000 + i));
      cyc();
    end
    chk("t2_full",  64'(o_full),  64'd1);
    chk("t2_ready", 64'(o_push_ready), 64'd0);
    chk("t2_count", 64'(o_count), 64'd4);
    set_push(1, 32'h10, 32'hA010);
    cyc();
    chk("t2_refuse", 64'(o_count), 64'd4);
    set_push(0, '0, '0);
    i_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_order", 64'(o_pc), 64'(4*i));
      cyc();
    end
    chk("t2_drained", 64'(o_valid), 64'd0);
    set_push(1, 32'h10, 32'hA010);
    cyc();
    set_push(0, '0, '0);
    #1 chk("t2_repush", 64'(o_pc), 64'h10);
    cyc();

    // full queue, pop and push together
    i_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_push(1, AW'(32'h20 + 4*i), DW'(i));
      cyc();
    end
    i_busy = 1'b0;
    set_push(1, 32'h30, 32'h30);
    #1 chk("t3_ready_full", 64'(o_push_ready), 64'd0);
    cyc();
    set_push(0, '0, '0);
    #1;
    chk("t3_count", 64'(o_count), 64'd3);
    chk("t3_ready", 64'(o_push_ready), 64'd1);
    chk("t3_head",  64'(o_pc), 64'h24);
    repeat (3) cyc();
    chk("t3_empty", 64'(o_empty), 64'd1);

    // steady stream, pointers wrap
    for (int i = 0; i < 20; i++) begin
      set_push(1, AW'(32'h1000 + 4*i), DW'(32'h5000 + i));
      cyc();
      #1;
      chk("t4_count", 64'(o_count), 64'd1);
      chk("t4_pc",    64'(o_pc),    64'(32'h1000 + 4*i));
    end
    set_push(0, '0, '0);
    cyc();

    // flush with concurrent push
    i_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(1, AW'(32'h300 + 4*i), DW'(i));
      cyc();
    end
    i_flush = 1'b1;
    set_push(1, 32'h200, 32'h200);
    #1 chk("t5_valid_flush", 64'(o_valid), 64'd0);
    cyc();
    i_flush = 1'b0;
    set_push(0, '0, '0);
    #1;
    chk("t5_empty", 64'(o_empty), 64'd1);
    chk("t5_count", 64'(o_count), 64'd0);
    cyc();
    chk("t5_no200", 64'(o_valid), 64'd0);

    // asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin
      set_push(1, AW'(32'h400 + 4*i), DW'(i));
      cyc();
    end
    set_push(0, '0, '0);
    chk("t6_pre", 64'(o_count), 64'd2);
    #1 i_reset = 1'b0;
    #1;
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_count", 64'(o_count), 64'd0);
    #1 i_reset = 1'b1;
    i_busy = 1'b0;
    set_push(1, 32'h40, 32'h40);
    cyc();
    set_push(0, '0, '0);
    #1;
    chk("t6_valid2", 64'(o_valid), 64'd1);
    chk("t6_pc",     64'(o_pc),    64'h40);
    cyc();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      i_flush = ($urandom_range(0, 31) == 0);
      i_busy  = ($urandom_range(0, 9) < 4);
      set_push($urandom_range(0, 9) < 7, AW'($urandom), DW'($urandom));
      cyc();
    end
    i_flush = 1'b0;
    set_push(0, '0, '0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
